// File: rtl/sec_stream_decoder.sv
// sec_stream_decoder
// Two-stage streaming Hamming SEC / SECDED decoder with valid/ready handshakes
// on both sides and saturating error statistics.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   input handshake
//   in_data          received data word (DATA_W)
//   in_chk           received check bits (CHK_W+1), MSB = overall parity
//   corr_en          1 = correct single data-bit errors, 0 = detect only
//   out_valid/ready  output handshake
//   out_data         corrected (or passed-through) data
//   out_syndrome     computed syndrome
//   out_corr         single (correctable) error found
//   out_uncorr       uncorrectable error found
//   cnt_clr          synchronous clear of both counters
//   cnt_corr         saturating count of transfers with out_corr
//   cnt_uncorr       saturating count of transfers with out_uncorr
module sec_stream_decoder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CHK_W  = 6,
  parameter int unsigned SECDED = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W:0]    in_chk,
  input  logic              corr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_syndrome,
  output logic              out_corr,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  // Column of data bit idx: the idx-th integer >= 3 that is not a power of two.
  function automatic int unsigned data_col(input int unsigned idx);
    int unsigned k;
    int unsigned res;
    k   = 0;
    res = 0;
    for (int unsigned v = 3; v < 256; v++) begin
      if ((v & (v - 1)) != 0) begin
        if (k == idx && res == 0) res = v;
        k++;
      end
    end
    return res;
  endfunction

  logic [CHK_W-1:0] cols [DATA_W];

  for (genvar g = 0; g < DATA_W; g++) begin : g_cols
    assign cols[g] = CHK_W'(data_col(g));
  end

  // Stage 1 registers
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_corr_en;
  logic [CHK_W-1:0]  s1_syn;
  logic              s1_par;

  logic              adv2;
  logic [CHK_W-1:0]  syn;
  logic              par;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;

  always_comb begin
    syn = in_chk[CHK_W-1:0];
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (in_data[i]) syn = syn ^ cols[i];
    end
    par = ^{in_data, in_chk};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_corr_en <= 1'b0;
      s1_syn     <= '0;
      s1_par     <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data    <= in_data;
        s1_corr_en <= corr_en;
        s1_syn     <= syn;
        s1_par     <= par;
      end
    end
  end

  // Classification of the stage-1 word
  logic [DATA_W-1:0] flip;
  logic              hit;
  logic              onehot;
  logic              c_corr;
  logic              c_uncorr;
  logic              do_flip;
  logic [DATA_W-1:0] c_data;

  always_comb begin
    flip = '0;
    hit  = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (s1_syn == cols[i]) begin
        flip[i] = 1'b1;
        hit     = 1'b1;
      end
    end
    onehot   = (s1_syn != '0) && ((s1_syn & (s1_syn - CHK_W'(1))) == '0);
    c_corr   = 1'b0;
    c_uncorr = 1'b0;
    do_flip  = 1'b0;
    if (s1_syn == '0) begin
      // zero syndrome with odd parity means only the overall-parity bit flipped
      c_corr = (SECDED != 0) && s1_par;
    end else if ((SECDED != 0) && !s1_par) begin
      // even parity with nonzero syndrome: double error, never corrected
      c_uncorr = 1'b1;
    end else begin
      c_corr   = hit || onehot;
      c_uncorr = !(hit || onehot);
      do_flip  = hit && s1_corr_en;
    end
    c_data = do_flip ? (s1_data ^ flip) : s1_data;
  end

  // Stage 2 (output) registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_corr     <= 1'b0;
      out_uncorr   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= c_data;
        out_syndrome <= s1_syn;
        out_corr     <= c_corr;
        out_uncorr   <= c_uncorr;
      end
    end
  end

  // Saturating statistics, counted on the output handshake; clear has priority
  logic out_hs;
  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (out_hs) begin
      if (out_corr && (cnt_corr != '1))     cnt_corr   <= cnt_corr + CNT_W'(1);
      if (out_uncorr && (cnt_uncorr != '1)) cnt_uncorr <= cnt_uncorr + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sec_stream_decoder.sv
// Bench for sec_stream_decoder: drives the same stream into a SEC instance
// (4-bit counters) and a SECDED instance (16-bit counters); expectations are
// queued at the input handshake and compared while each word sits at the output.
module tb_sec_stream_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [6:0]  in_chk;
  logic        corr_en;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready_a, out_valid_a, out_corr_a, out_unc_a;
  logic [31:0] out_data_a;
  logic [5:0]  out_syn_a;
  logic [3:0]  cnt_corr_a, cnt_unc_a;

  logic        in_ready_b, out_valid_b, out_corr_b, out_unc_b;
  logic [31:0] out_data_b;
  logic [5:0]  out_syn_b;
  logic [15:0] cnt_corr_b, cnt_unc_b;

  sec_stream_decoder #(.DATA_W(32), .CHK_W(6), .SECDED(0), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_chk(in_chk), .corr_en(corr_en),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_syndrome(out_syn_a), .out_corr(out_corr_a), .out_uncorr(out_unc_a),
    .cnt_clr(cnt_clr), .cnt_corr(cnt_corr_a), .cnt_uncorr(cnt_unc_a)
  );

  sec_stream_decoder #(.DATA_W(32), .CHK_W(6), .SECDED(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_chk(in_chk), .corr_en(corr_en),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_syndrome(out_syn_b), .out_corr(out_corr_b), .out_uncorr(out_unc_b),
    .cnt_clr(cnt_clr), .cnt_corr(cnt_corr_b), .cnt_uncorr(cnt_unc_b)
  );

  typedef struct {
    logic [31:0] da; logic [5:0] sa; logic ca; logic ua;
    logic [31:0] db; logic [5:0] sb; logic cb; logic ub;
    int acc; bit lat;
  } exp_t;

  exp_t        q[$];
  int unsigned tcol [32];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mode = 0;
  int          step = 0;
  int          mca = 0, mua = 0, mcb = 0, mub = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decoder: column table by popcount, classification by case.
  function automatic void decode(input logic [31:0] d, input logic [6:0] c, input logic en,
                                 input bit sd, output logic [31:0] od, output logic [5:0] s,
                                 output logic cr, output logic un);
    logic p;
    int   hit;
    s = c[5:0];
    for (int i = 0; i < 32; i++) if (d[i]) s = s ^ 6'(tcol[i]);
    p   = ^{d, c};
    od  = d;
    cr  = 1'b0;
    un  = 1'b0;
    hit = -1;
    for (int i = 0; i < 32; i++) if (6'(tcol[i]) == s) hit = i;
    if (s == 6'd0)           cr = sd && p;
    else if (sd && !p)       un = 1'b1;
    else if (hit >= 0) begin cr = 1'b1; if (en) od[hit] = ~od[hit]; end
    else if ($countones(s) == 1) cr = 1'b1;
    else                     un = 1'b1;
  endfunction

  always @(negedge clk) begin
    case (mode)
      0: out_ready = 1'b1;
      1: begin out_ready = (step % 4 == 0) || (step % 4 == 3); step++; end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [31:0] d, input logic [6:0] c, input logic en);
    exp_t e;
    bit   done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_chk = c; corr_en = en;
    decode(d, c, en, 1'b0, e.da, e.sa, e.ca, e.ua);
    decode(d, c, en, 1'b1, e.db, e.sb, e.cb, e.ub);
    e.lat = (mode == 0);
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (in_ready_a) begin
        e.acc = cyc;
        @(posedge clk);
        q.push_back(e);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("in_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic send_coded(input int nerr);
    logic [31:0] d;
    logic [5:0]  c6;
    logic [38:0] w;
    int          a, b;
    d  = $urandom;
    c6 = '0;
    for (int i = 0; i < 32; i++) if (d[i]) c6 = c6 ^ 6'(tcol[i]);
    w = {^{d, c6}, c6, d};
    a = $urandom_range(0, 38);
    b = (a + 1 + $urandom_range(0, 37)) % 39;
    if (nerr >= 1) w[a] = ~w[a];
    if (nerr >= 2) w[b] = ~w[b];
    send(w[31:0], w[38:32], 1'($urandom_range(0, 1)));
  endtask

  // Output monitor / scoreboard, sampled 2 time units after the falling edge
  always @(negedge clk) begin
    bit hs;
    #2;
    if (rst_n) begin
      hs = out_valid_a && out_ready;
      if (q.size() == 0) begin
        check("ovalid_a", {63'd0, out_valid_a}, 64'd0);
        check("ovalid_b", {63'd0, out_valid_b}, 64'd0);
      end else if (out_valid_a) begin
        check("data_a", out_data_a, q[0].da);
        check("syn_a",  out_syn_a,  q[0].sa);
        check("corr_a", out_corr_a, q[0].ca);
        check("unc_a",  out_unc_a,  q[0].ua);
        check("ovalid_b", {63'd0, out_valid_b}, 64'd1);
        check("data_b", out_data_b, q[0].db);
        check("syn_b",  out_syn_b,  q[0].sb);
        check("corr_b", out_corr_b, q[0].cb);
        check("unc_b",  out_unc_b,  q[0].ub);
        if (hs && q[0].lat) check("latency", 64'(cyc - q[0].acc), 64'd2);
      end
      if (out_valid_a && !out_ready) begin
        check("in_ready_a", {63'd0, in_ready_a}, {63'd0, q.size() < 2});
        check("in_ready_b", {63'd0, in_ready_b}, {63'd0, q.size() < 2});
      end else begin
        check("in_ready_a", {63'd0, in_ready_a}, 64'd1);
        check("in_ready_b", {63'd0, in_ready_b}, 64'd1);
      end
      check("cnt_corr_a", cnt_corr_a, 64'(mca));
      check("cnt_unc_a",  cnt_unc_a,  64'(mua));
      check("cnt_corr_b", cnt_corr_b, 64'(mcb));
      check("cnt_unc_b",  cnt_unc_b,  64'(mub));
      if (cnt_clr) begin
        mca = 0; mua = 0; mcb = 0; mub = 0;
      end else if (hs && q.size() != 0) begin
        if (q[0].ca && mca < 15)    mca++;
        if (q[0].ua && mua < 15)    mua++;
        if (q[0].cb && mcb < 65535) mcb++;
        if (q[0].ub && mub < 65535) mub++;
      end
      if (hs && q.size() != 0) void'(q.pop_front());
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_chk = '0;
    corr_en = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    n = 0;
    for (int unsigned v = 3; n < 32; v++) if ($countones(v) != 1) begin tcol[n] = v; n++; end

    repeat (3) @(negedge clk);
    #1;
    check("rst_ovalid", {63'd0, out_valid_a}, 64'd0);
    check("rst_data",   out_data_a, 64'd0);
    check("rst_syn",    out_syn_b, 64'd0);
    check("rst_flags",  {out_corr_a, out_unc_a, out_corr_b, out_unc_b}, 64'd0);
    check("rst_cnt",    {cnt_corr_a, cnt_unc_a, cnt_corr_b, cnt_unc_b}, 64'd0);
    rst_n = 1'b1;

    // directed vectors
    mode = 0;
    send(32'h0000_0000, 7'h00, 1'b1);
    send(32'h0000_0001, 7'h00, 1'b1);
    send(32'h0000_0001, 7'h00, 1'b0);
    send(32'h8000_0000, 7'h00, 1'b1);
    send(32'h0000_0000, 7'h04, 1'b1);
    send(32'h0000_0000, 7'h3F, 1'b1);
    send(32'h0000_0003, 7'h00, 1'b1);
    send(32'h0000_0000, 7'h40, 1'b1);
    idle();
    drain();

    // back-pressure pattern 1,0,0,1
    mode = 1; step = 0;
    for (int i = 0; i < 8; i++) send($urandom, 7'($urandom), 1'b1);
    idle();
    drain();

    // random codewords with 0/1/2 flipped bits and random back-pressure
    mode = 2;
    for (int i = 0; i < 40; i++) send_coded(i % 3);
    idle();
    mode = 0;
    drain();

    // saturation of the 4-bit counter
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) send(32'h0000_0001, 7'h00, 1'b1);
    idle();
    drain();
    @(negedge clk);
    check("sat_corr_a", cnt_corr_a, 64'd15);
    check("sum_corr_b", cnt_corr_b, 64'd20);

    // clear coinciding with a counted output handshake
    fork
      for (int i = 0; i < 6; i++) send(32'h0000_0001, 7'h00, 1'b1);
      begin
        repeat (4) @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
      end
    join
    idle();
    drain();

    // reset while both stages hold words
    mode = 3;
    send(32'h1234_5678, 7'h00, 1'b1);
    send(32'h0000_0001, 7'h00, 1'b1);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ovalid", {63'd0, out_valid_a, out_valid_b}, 64'd0);
    check("midrst_cnt", {cnt_corr_a, cnt_unc_a, cnt_corr_b, cnt_unc_b}, 64'd0);
    check("midrst_data", out_data_b, 64'd0);
    q.delete();
    mca = 0; mua = 0; mcb = 0; mub = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    mode = 0;
    send(32'hDEAD_BEEF, 7'h00, 1'b1);
    idle();
    drain();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sec_stream_decoder.md
Name: sec_stream_decoder

Overview:
- Streaming, parametrised single-error-correcting decoder: the clocked, handshaked successor of the 32-bit combinational SEC circuit family.
- Accepts one data word plus check bits per transfer and computes a Hamming syndrome.
- Corrects single-bit errors and flags uncorrectable words, with optional SECDED double-error detection.
- Keeps saturating error statistics; sits between a protected memory/link and its consumer.

Parameters:
- DATA_W, 32, data word width (4..57).
- CHK_W, 6, Hamming check bits; must satisfy 2^CHK_W >= DATA_W+CHK_W+1.
- SECDED, 1, 1 = overall-parity bit used (double-error detect), 0 = pure SEC.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept.
- in_data  in  DATA_W  received data.
- in_chk  in  CHK_W+1  received check bits; MSB = overall parity (ignored when SECDED=0).
- corr_en  in  1  1 = correct data, 0 = detect only; sampled with the word.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  corrected (or passed) data.
- out_syndrome  out  CHK_W  computed syndrome.
- out_corr  out  1  single error found (and corrected if corr_en).
- out_uncorr  out  1  uncorrectable error.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_corr  out  CNT_W  saturating count of out_corr transfers.
- cnt_uncorr  out  CNT_W  saturating count of out_uncorr transfers.

Behaviour:
- Reset (async, rst_n=0): all pipeline valids 0; out_data, out_syndrome, out_corr, out_uncorr, cnt_corr, cnt_uncorr = 0; in_ready = 1 once reset is released. Reset mid-stream drops all in-flight words.
- Code definition:
  - Data bit i gets column c_i = the i-th integer >= 3 that is not a power of two, taken in ascending order (DATA_W=32: bit0=3, bit1=5, bit2=6, bit3=7, bit4=9 ... bit31=38).
  - Check bit j gets column 2^j.
  - Syndrome s = in_chk[CHK_W-1:0] XOR (XOR of c_i over all i with in_data[i]=1).
  - Overall parity p = XOR of all in_data bits and all in_chk bits (including MSB); p=0 means even.
- Classification for SECDED=0:
  - s=0: clean.
  - s = some c_i: flip data bit i if corr_en; out_corr=1.
  - s one-hot: check-bit error; data unchanged; out_corr=1.
  - Any other s: out_uncorr=1; data unchanged.
- Classification for SECDED=1:
  - s=0, p=0: clean.
  - s=0, p=1: parity-bit error; out_corr=1.
  - s!=0, p=1: classify as for SEC. An invalid s gives out_uncorr.
  - s!=0, p=0: double error; out_uncorr=1; no correction.
- out_corr and out_uncorr are mutually exclusive. corr_en=0 never modifies data; flags are still reported.
- Pipeline (2 stages):
  - Stage 1 registers in_data, in_chk, corr_en, syndrome and parity.
  - Stage 2 registers the corrected result and flags.
  - Latency is 2 cycles from input handshake to out_valid with no stalls; throughput is 1 word per cycle.
- Handshake:
  - Transfer occurs when valid and ready are both 1.
  - adv2 = !out_valid | out_ready.
  - Stage 1 moves to stage 2 when it is valid and adv2.
  - in_ready = !s1_valid | adv2 (combinational from out_ready).
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - No word is dropped or duplicated under any valid/ready pattern.
- Counters:
  - Increment on the output handshake when the corresponding flag is 1.
  - Saturate at 2^CNT_W-1.
  - cnt_clr sets both to 0 next cycle; clear wins over a simultaneous increment.

Test Plan:
- DATA_W=32, SECDED=0: data=0x00000000, chk=0 → 2 cycles later out_data=0, s=0, corr=0, uncorr=0.
- data=0x00000001, chk=0, corr_en=1 → out_data=0x00000000, s=3, out_corr=1, cnt_corr=1. Same stimulus with corr_en=0 → out_data=0x00000001, out_corr=1.
- data=0x80000000, chk=0 → out_data=0, s=38. data=0, chk=6'h04 → out_data=0, s=4, out_corr=1. data=0, chk=6'h3F → out_uncorr=1, cnt_uncorr increments.
- SECDED=1: data=0x00000003, chk=0 (s=3^5=6 → wait: s=6 maps to bit2, but p=0) → out_uncorr=1 with data unchanged. data=0, chk=7'h40 → out_corr=1.
- Back-pressure: stream 8 words with out_ready toggling 1,0,0,1,... → outputs in order, none lost or duplicated, outputs stable while stalled, in_ready=0 only when both stages are full and stalled.
- Counter edges:
  - CNT_W=4, 20 corrupted words → cnt_corr=15.
  - cnt_clr asserted in the same cycle as an increment → counter reads 0.
  - rst_n pulsed low mid-stream → out_valid=0 and counters 0 immediately.
